// File: rtl/r_cordic_unit.sv
// Iterative rotation-mode CORDIC: rotates (x, y) by a Q3.29 angle, one micro-rotation per clock.
// Optional gain compensation by K = 0.607252935 on the final SCALE step.
module r_cordic_unit #(
  parameter int ITERATIONS = 16,
  parameter int GAIN_COMP  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_data_1,
  input  logic [31:0] i_data_2,
  input  logic [31:0] i_angle,
  input  logic        en,
  output logic [31:0] o_data_1,
  output logic [31:0] o_data_2,
  output logic [31:0] o_angle,
  output logic        busy,
  output logic        done_flag
);

  localparam int DATA_W = 32;
  localparam int ACC_W  = DATA_W + 2;
  localparam int PROD_W = ACC_W + DATA_W;

  localparam logic signed [DATA_W-1:0] HALF_PI = 32'sh3243F6A8;
  localparam logic signed [DATA_W-1:0] PI      = 32'sh6487ED51;
  localparam logic signed [DATA_W-1:0] K_GAIN  = 32'sh26DD3B6A;
  localparam logic [3:0]               LAST_IT = 4'(ITERATIONS - 1);

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  state_t                    state, state_nxt;
  logic [3:0]                it_p0;
  logic signed [ACC_W-1:0]   x_p0, y_p0;
  logic signed [DATA_W-1:0]  z_p0;

  logic signed [DATA_W-1:0]  ang_in, z_in;
  logic signed [ACC_W-1:0]   x_in, y_in;
  logic signed [ACC_W-1:0]   x_sh, y_sh, x_nxt, y_nxt;
  logic signed [DATA_W-1:0]  z_nxt;

  function automatic logic signed [DATA_W-1:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    return 32'sh1921FB54;
      4'd1:    return 32'sh0ED63383;
      4'd2:    return 32'sh07D6DD7E;
      4'd3:    return 32'sh03FAB753;
      4'd4:    return 32'sh01FF55BB;
      4'd5:    return 32'sh00FFEAAE;
      4'd6:    return 32'sh007FFD55;
      4'd7:    return 32'sh003FFFAB;
      4'd8:    return 32'sh001FFFF5;
      4'd9:    return 32'sh000FFFFF;
      4'd10:   return 32'sh00080000;
      4'd11:   return 32'sh00040000;
      4'd12:   return 32'sh00020000;
      4'd13:   return 32'sh00010000;
      4'd14:   return 32'sh00008000;
      default: return 32'sh00004000;
    endcase
  endfunction

  // Multiply by K (Q1.30) and drop 30 fraction bits; arithmetic shift rounds toward -inf.
  function automatic logic signed [DATA_W-1:0] gain_scale(input logic signed [ACC_W-1:0] v);
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(v) * PROD_W'(K_GAIN);
    return DATA_W'(prod >>> 30);
  endfunction

  function automatic logic signed [DATA_W-1:0] wrap_out(input logic signed [ACC_W-1:0] v);
    return DATA_W'(v);
  endfunction

  // Pre-rotation by pi folds the angle into [-pi/2, pi/2], inside CORDIC convergence.
  always_comb begin
    ang_in = $signed(i_angle);
    x_in   = ACC_W'($signed(i_data_1));
    y_in   = ACC_W'($signed(i_data_2));
    z_in   = ang_in;
    if (ang_in > HALF_PI) begin
      x_in = -x_in;
      y_in = -y_in;
      z_in = ang_in - PI;
    end else if (ang_in < -HALF_PI) begin
      x_in = -x_in;
      y_in = -y_in;
      z_in = ang_in + PI;
    end
  end

  always_comb begin
    x_sh = x_p0 >>> it_p0;
    y_sh = y_p0 >>> it_p0;
    if (z_p0[DATA_W-1]) begin
      x_nxt = x_p0 + y_sh;
      y_nxt = y_p0 - x_sh;
      z_nxt = z_p0 + atan_lut(it_p0);
    end else begin
      x_nxt = x_p0 - y_sh;
      y_nxt = y_p0 + x_sh;
      z_nxt = z_p0 - atan_lut(it_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      it_p0 <= '0;
    end else begin
      state <= state_nxt;
      it_p0 <= (state == ITER) ? it_p0 + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done_flag = 1'b0;
    case (state)
      IDLE:  if (en) state_nxt = ITER;
      ITER: begin
        busy = 1'b1;
        if (it_p0 == LAST_IT) state_nxt = SCALE;
      end
      SCALE: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done_flag = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: loaded on accept, updated each ITER edge, otherwise held.
  always_ff @(posedge clk) begin
    if (state == IDLE && en) begin
      x_p0 <= x_in;
      y_p0 <= y_in;
      z_p0 <= z_in;
    end else if (state == ITER) begin
      x_p0 <= x_nxt;
      y_p0 <= y_nxt;
      z_p0 <= z_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data_1 <= '0;
      o_data_2 <= '0;
      o_angle  <= '0;
    end else if (state == SCALE) begin
      if (GAIN_COMP != 0) begin
        o_data_1 <= gain_scale(x_p0);
        o_data_2 <= gain_scale(y_p0);
      end else begin
        o_data_1 <= wrap_out(x_p0);
        o_data_2 <= wrap_out(y_p0);
      end
      o_angle <= z_p0;
    end
  end

endmodule

// File: tb/tb_r_cordic_unit.sv
// Directed bench for r_cordic_unit: latency, accuracy, pre-rotation, handshake, hold and abort.
module tb_r_cordic_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] i_data_1 = '0;
  logic [31:0] i_data_2 = '0;
  logic [31:0] i_angle  = '0;
  logic signed [31:0] o_data_1, o_data_2, o_angle;
  logic signed [31:0] raw_d1, raw_d2, raw_ang;
  logic        busy, done_flag, raw_busy, raw_done;

  int     checks = 0;
  int     errors = 0;
  longint px = 0;
  longint py = 0;

  localparam logic [31:0] ANG_0   = 32'h00000000;
  localparam logic [31:0] ANG_P4  = 32'h1921FB54;
  localparam logic [31:0] ANG_P2  = 32'h3243F6A8;
  localparam logic [31:0] ANG_PI  = 32'h6487ED51;
  localparam logic [31:0] ANG_M2  = 32'hC0000000;

  always #5 clk = ~clk;

  r_cordic_unit #(.ITERATIONS(16), .GAIN_COMP(1)) dut (
    .clk(clk), .rst(rst), .i_data_1(i_data_1), .i_data_2(i_data_2), .i_angle(i_angle),
    .en(en), .o_data_1(o_data_1), .o_data_2(o_data_2), .o_angle(o_angle),
    .busy(busy), .done_flag(done_flag)
  );

  r_cordic_unit #(.ITERATIONS(16), .GAIN_COMP(0)) dut_raw (
    .clk(clk), .rst(rst), .i_data_1(i_data_1), .i_data_2(i_data_2), .i_angle(i_angle),
    .en(en), .o_data_1(raw_d1), .o_data_2(raw_d2), .o_angle(raw_ang),
    .busy(raw_busy), .done_flag(raw_done)
  );

  task automatic chk(input string tag, input longint act, input longint exp, input longint tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, act, exp, tol);
    end
  endtask

  // Starts a job from a negedge; returns at the negedge where done_flag is seen (or budget out).
  task automatic run_job(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ang,
                         input bit noisy, output int wt, output int lat, output int bcnt);
    bit acc;
    i_data_1 = x;
    i_data_2 = y;
    i_angle  = ang;
    en       = 1'b1;
    acc      = 1'b0;
    wt       = 0;
    while (!acc && wt < 4) begin
      @(posedge clk);
      @(negedge clk);
      wt++;
      acc = busy;
    end
    en = 1'b0;
    if (noisy) begin
      i_data_1 = 32'd30000;
      i_data_2 = 32'd12345;
      i_angle  = ANG_0;
    end
    lat  = -1;
    bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_flag) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
      if (k == 8) begin
        chk("hold_x", o_data_1, px, 8);
        chk("hold_y", o_data_2, py, 8);
      end
      en = noisy && (k == 3 || k == 9);
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic job(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ang, input bit noisy, input longint e1,
                     input longint e2, input int exp_wt);
    int wt, lat, bcnt;
    run_job(x, y, ang, noisy, wt, lat, bcnt);
    chk({tag, "_accept"}, wt, exp_wt, 0);
    chk({tag, "_latency"}, lat, 17, 0);
    chk({tag, "_busy_cycles"}, bcnt, 17, 0);
    chk({tag, "_x"}, o_data_1, e1, 8);
    chk({tag, "_y"}, o_data_2, e2, 8);
    px = e1;
    py = e2;
  endtask

  task automatic count_done(input string tag, input int n);
    int dcnt;
    dcnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done_flag) dcnt++;
    end
    chk(tag, dcnt, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with en asserted: reset must win.
    en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x", o_data_1, 0, 0);
    chk("rst_y", o_data_2, 0, 0);
    chk("rst_ang", o_angle, 0, 0);
    chk("rst_busy", busy, 0, 0);
    chk("rst_done", done_flag, 0, 0);
    en  = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    job("a0", 32'd65536, 32'd0, ANG_0, 1'b0, 65536, 0, 1);
    chk("a0_resid", o_angle, 0, 16388);
    chk("raw_done", raw_done, 1, 0);
    chk("raw_x", raw_d1, 107925, 8);
    @(negedge clk);
    chk("pulse_done", done_flag, 0, 0);
    chk("pulse_busy", busy, 0, 0);

    job("p4", 32'd65536, 32'd0, ANG_P4, 1'b0, 46341, 46341, 1);
    @(negedge clk);
    job("pi", 32'd65536, 32'd0, ANG_PI, 1'b0, -65536, 0, 1);
    @(negedge clk);
    job("p2", 32'd65536, 32'd0, ANG_P2, 1'b0, 0, 65536, 1);
    @(negedge clk);
    job("m2", 32'd65536, 32'd0, ANG_M2, 1'b0, -27273, -59591, 1);
    @(negedge clk);

    // Extra en pulses and input changes while busy must be ignored.
    job("noisy", 32'd65536, 32'd0, ANG_P2, 1'b1, 0, 65536, 1);
    count_done("noisy_extra_done", 25);

    // Back-to-back: second en presented on the done cycle, accepted at the first IDLE edge.
    job("r1", 32'd65536, 32'd0, ANG_0, 1'b0, 65536, 0, 1);
    job("r2", 32'd65536, 32'd0, ANG_P4, 1'b0, 46341, 46341, 2);
    @(negedge clk);

    // Abort mid-iteration.
    i_data_1 = 32'd100000;
    i_data_2 = 32'd0;
    i_angle  = ANG_P4;
    en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    chk("ab_started", busy, 1, 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("ab_x", o_data_1, 0, 0);
    chk("ab_y", o_data_2, 0, 0);
    chk("ab_ang", o_angle, 0, 0);
    chk("ab_busy", busy, 0, 0);
    chk("ab_done", done_flag, 0, 0);
    px = 0;
    py = 0;
    count_done("ab_no_done", 25);

    job("yin", 32'd0, 32'd65536, ANG_P2, 1'b0, -65536, 0, 1);
    @(negedge clk);
    job("big", 32'd100000, 32'd0, ANG_P4, 1'b0, 70711, 70711, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
